// File: rtl/mole_round_ctrl_pkg.sv
// Shared definitions for the whack-a-mole round sequencer and its display logic.
package mole_round_ctrl_pkg;

  localparam int unsigned DEF_N = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_SEL = 3'd2,
    ST_SHOW     = 3'd3,
    ST_GAP      = 3'd4,
    ST_END      = 3'd5
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_tick_timer.sv
// Loadable down-counter that stops at zero; zero flag is combinational from the count.
module tick_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: draws 2^N moles from unique_selector, shows each, scores hits.
module mole_round_ctrl
  import mole_round_ctrl_pkg::*;
#(
  parameter int unsigned N           = DEF_N,
  parameter int unsigned SHOW_TICKS  = 16,
  parameter int unsigned GAP_TICKS   = 4,
  parameter int unsigned SEL_TIMEOUT = 32,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [2**N-1:0]    hit_btn,
  output logic               sel_req,
  input  logic [N-1:0]       sel_num,
  input  logic               sel_done,
  input  logic               sel_all,
  output logic               sel_rst,
  output logic [2**N-1:0]    mole_onehot,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss,
  output logic               busy,
  output logic               round_done,
  output logic               sel_err
);

  localparam int unsigned M    = 2**N;
  localparam int unsigned TMAX = max3(SHOW_TICKS, GAP_TICKS, SEL_TIMEOUT);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [M-1:0] ONE = M'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  mole_idx;
  logic [N:0]    mole_cnt;
  logic          sel_all_q;
  logic          abort_rst_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  logic clr, latch, hit, miss_inc, set_err, abort_rst;

  tick_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  // Loading N-1 makes each phase last exactly N cycles, counting the zero cycle.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    clr       = 1'b0;
    latch     = 1'b0;
    hit       = 1'b0;
    miss_inc  = 1'b0;
    set_err   = 1'b0;
    abort_rst = 1'b0;
    if (state_q != ST_IDLE && abort) begin
      state_d   = ST_IDLE;
      abort_rst = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            clr     = 1'b1;
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          tmr_load = 1'b1;
          tmr_val  = TW'(SEL_TIMEOUT - 1);
          state_d  = ST_WAIT_SEL;
        end
        ST_WAIT_SEL: begin
          if (sel_done) begin
            latch    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TW'(SHOW_TICKS - 1);
            state_d  = ST_SHOW;
          end else if (tmr_zero) begin
            set_err   = 1'b1;
            abort_rst = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_SHOW: begin
          if (hit_btn[mole_idx] || tmr_zero) begin
            hit      = hit_btn[mole_idx];
            miss_inc = ~hit_btn[mole_idx];
            tmr_load = 1'b1;
            tmr_val  = TW'(GAP_TICKS - 1);
            state_d  = ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_zero) begin
            state_d = (mole_cnt == (N+1)'(M) || sel_all_q) ? ST_END : ST_REQ;
          end
        end
        ST_END:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mole_idx    <= '0;
      mole_cnt    <= '0;
      sel_all_q   <= 1'b0;
      abort_rst_q <= 1'b0;
      mole_onehot <= '0;
      score       <= '0;
      miss        <= '0;
      sel_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      abort_rst_q <= abort_rst;
      if (clr) begin
        score     <= '0;
        miss      <= '0;
        sel_err   <= 1'b0;
        mole_cnt  <= '0;
        sel_all_q <= 1'b0;
      end
      if (set_err) sel_err <= 1'b1;
      if (latch) begin
        mole_idx  <= sel_num;
        sel_all_q <= sel_all;
        if (mole_cnt != '1) mole_cnt <= mole_cnt + 1'b1;
      end
      if (hit && score != '1) score <= score + 1'b1;
      if (miss_inc && miss != '1) miss <= miss + 1'b1;
      mole_onehot <= (state_d == ST_SHOW) ? (latch ? (ONE << sel_num) : mole_onehot) : '0;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign sel_req    = (state_q == ST_REQ);
  assign round_done = (state_q == ST_END);
  assign sel_rst    = round_done | abort_rst_q;

endmodule
